// File: rtl/param_sync_sram_pkg.sv
// Shared types and constants for param_sync_sram: FSM states, decoded
// commands and the request decoder used by the top level.
package sram_pkg;

    localparam int RD_LAT_MAX = 2;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } sram_state_e;

    typedef enum logic [1:0] {
        CMD_NOP = 2'd0,
        CMD_WR  = 2'd1,
        CMD_RD  = 2'd2,
        CMD_ERR = 2'd3
    } sram_cmd_e;

    // A request with both we and rd set is rejected even when the address is valid.
    function automatic sram_cmd_e decode_cmd(
        input logic i_cs,
        input logic i_we,
        input logic i_rd,
        input logic i_in_range
    );
        sram_cmd_e w_cmd;
        if (!i_cs || (!i_we && !i_rd)) begin
            w_cmd = CMD_NOP;
        end else if (i_we && i_rd) begin
            w_cmd = CMD_ERR;
        end else if (!i_in_range) begin
            w_cmd = CMD_ERR;
        end else if (i_we) begin
            w_cmd = CMD_WR;
        end else begin
            w_cmd = CMD_RD;
        end
        return w_cmd;
    endfunction

endpackage

// File: rtl/param_sync_sram_if.sv
// Bus bundle between a controller (master) and param_sync_sram (slave).
interface param_sync_sram_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int BE_W   = DATA_W / 8
);
    logic              cs;
    logic              we;
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] dout;
    logic              rd_valid;
    logic              busy;
    logic              err;

    modport master (
        output cs, we, rd, addr, din, be,
        input  dout, rd_valid, busy, err
    );

    modport slave (
        input  cs, we, rd, addr, din, be,
        output dout, rd_valid, busy, err
    );
endinterface

// File: rtl/param_sync_sram_array.sv
// Storage only: one byte-enabled write port and one synchronous read port
// sharing a single address, no reset on the contents or the read register.
module sram_array #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = 8,
    parameter int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [BE_W-1:0]   i_be,
    input  logic              i_re,
    input  logic [IDX_W-1:0]  i_addr,
    input  logic [DATA_W-1:0] i_din,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Byte-lane write; lanes with a clear enable keep their old contents.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_din[8*b +: 8];
                end
            end
        end
    end

    // Read register only updates on an accepted read, so it holds between reads.
    always_ff @(posedge clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/param_sync_sram.sv
// Parametrised single-port SRAM: post-reset clear sequencer, request decode,
// 1- or 2-cycle read latency with rd_valid, and a rejected-access err strobe.
module param_sync_sram
    import sram_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 1,
    parameter int BE_W   = DATA_W / 8
) (
    input logic              clk,
    input logic              rst_n,
    param_sync_sram_if.slave bus
);
    localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

    generate
        if (DEPTH < 1 || longint'(DEPTH) > (64'd1 << ADDR_W)) begin : g_bad_depth
            $error("param_sync_sram: DEPTH must be in 1..2**ADDR_W");
        end
        if (DATA_W % 8 != 0) begin : g_bad_width
            $error("param_sync_sram: DATA_W must be a multiple of 8");
        end
        if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
            $error("param_sync_sram: RD_LAT must be 1 or 2");
        end
    endgenerate

    sram_state_e       r_state;
    sram_state_e       w_state_nxt;
    logic [IDX_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  w_cnt_nxt;
    logic              w_in_range;
    sram_cmd_e         w_cmd;
    logic              w_arr_we;
    logic [BE_W-1:0]   w_arr_be;
    logic              w_arr_re;
    logic [IDX_W-1:0]  w_arr_idx;
    logic [DATA_W-1:0] w_arr_din;
    logic [DATA_W-1:0] w_rdata;
    logic              r_rv1;
    logic              r_err;
    logic [DATA_W-1:0] w_dout;
    logic              w_rv;

    assign w_in_range = ({1'b0, bus.addr} < DEPTH_L);
    assign w_cmd      = decode_cmd(bus.cs, bus.we, bus.rd, w_in_range);

    // Next state, clear counter and array port steering.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_arr_we    = 1'b0;
        w_arr_be    = '0;
        w_arr_re    = 1'b0;
        w_arr_idx   = bus.addr[IDX_W-1:0];
        w_arr_din   = bus.din;
        case (r_state)
            ST_INIT: begin
                w_arr_we  = 1'b1;
                w_arr_be  = '1;
                w_arr_idx = r_cnt;
                w_arr_din = '0;
                if (r_cnt == LAST_IDX) begin
                    w_state_nxt = ST_READY;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + IDX_W'(1);
                end
            end
            ST_READY: begin
                case (w_cmd)
                    CMD_WR: begin
                        w_arr_we = 1'b1;
                        w_arr_be = bus.be;
                    end
                    CMD_RD: begin
                        w_arr_re = 1'b1;
                    end
                    default: begin
                        w_arr_we = 1'b0;
                    end
                endcase
            end
            default: begin
                w_state_nxt = ST_INIT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State and clear-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // First read-pipeline stage and the error strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rv1 <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_rv1 <= w_arr_re;
            r_err <= (r_state == ST_READY) && (w_cmd == CMD_ERR);
        end
    end

    sram_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W),
        .BE_W   (BE_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_arr_we),
        .i_be    (w_arr_be),
        .i_re    (w_arr_re),
        .i_addr  (w_arr_idx),
        .i_din   (w_arr_din),
        .o_rdata (w_rdata)
    );

    generate
        if (RD_LAT == 1) begin : g_lat1
            logic r_rd_seen;

            // The array read register has no reset; mask it until the first read lands.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rd_seen <= 1'b0;
                end else begin
                    r_rd_seen <= r_rd_seen | w_arr_re;
                end
            end

            assign w_dout = r_rd_seen ? w_rdata : '0;
            assign w_rv   = r_rv1;
        end else begin : g_lat2
            logic              r_rv2;
            logic [DATA_W-1:0] r_dout2;

            // Second output register, loaded only when stage one holds fresh data.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rv2   <= 1'b0;
                    r_dout2 <= '0;
                end else begin
                    r_rv2 <= r_rv1;
                    if (r_rv1) begin
                        r_dout2 <= w_rdata;
                    end
                end
            end

            assign w_dout = r_dout2;
            assign w_rv   = r_rv2;
        end
    endgenerate

    assign bus.dout     = w_dout;
    assign bus.rd_valid = w_rv;
    assign bus.err      = r_err;
    assign bus.busy     = (r_state == ST_INIT);
endmodule

// File: tb/tb_param_sync_sram.sv
// Directed bench: an 8-bit RD_LAT=1 instance and a 32-bit RD_LAT=2 instance,
// both DEPTH=16, sharing clock and reset.
module tb_param_sync_sram;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    param_sync_sram_if #(.DATA_W(8),  .ADDR_W(8)) bus1 ();
    param_sync_sram_if #(.DATA_W(32), .ADDR_W(5)) bus2 ();

    param_sync_sram #(.DATA_W(8), .ADDR_W(8), .DEPTH(16), .RD_LAT(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    param_sync_sram #(.DATA_W(32), .ADDR_W(5), .DEPTH(16), .RD_LAT(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bus1.cs = 1'b0; bus1.we = 1'b0; bus1.rd = 1'b0;
        bus1.addr = 8'd0; bus1.din = 8'd0; bus1.be = 1'b0;
        bus2.cs = 1'b0; bus2.we = 1'b0; bus2.rd = 1'b0;
        bus2.addr = 5'd0; bus2.din = 32'd0; bus2.be = 4'd0;
    endtask

    task automatic wr1(input logic [7:0] a, input logic [7:0] d);
        bus1.cs = 1'b1; bus1.we = 1'b1; bus1.rd = 1'b0;
        bus1.addr = a; bus1.din = d; bus1.be = 1'b1;
    endtask

    task automatic rd1(input logic [7:0] a);
        bus1.cs = 1'b1; bus1.we = 1'b0; bus1.rd = 1'b1; bus1.addr = a;
    endtask

    task automatic test_reset();
        int n;
        idle_all();
        rst_n = 1'b0;
        tick();
        tick();
        n_vec++;
        if (bus1.busy !== 1'b1 || bus1.dout !== 8'h00 || bus1.rd_valid !== 1'b0 || bus1.err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: busy=%b dout=%h rv=%b err=%b, expected 1 00 0 0",
                     bus1.busy, bus1.dout, bus1.rd_valid, bus1.err);
        end
        n_vec++;
        if (bus2.dout !== 32'h0 || bus2.rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state2: dout=%h rv=%b, expected 0 0", bus2.dout, bus2.rd_valid);
        end
        rst_n = 1'b1;
        n = 0;
        while (bus1.busy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        n_vec++;
        if (n !== 16) begin
            n_err++;
            $display("FAIL busy_length: got %0d cycles, expected 16", n);
        end
        for (int k = 0; k < 16; k++) begin
            rd1(8'(k));
            tick();
            n_vec++;
            if (bus1.rd_valid !== 1'b1 || bus1.dout !== 8'h00) begin
                n_err++;
                $display("FAIL clear_read[%0d]: rv=%b dout=%h, expected 1 00", k, bus1.rd_valid, bus1.dout);
            end
        end
        idle_all();
        tick();
        n_vec++;
        if (bus1.rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL clear_read_end: rv=%b, expected 0", bus1.rd_valid);
        end
    endtask

    task automatic test_write_read();
        wr1(8'd3, 8'hA5);
        bus2.cs = 1'b1; bus2.we = 1'b1; bus2.addr = 5'd3; bus2.din = 32'h000000A5; bus2.be = 4'b0001;
        tick();
        rd1(8'd3);
        bus2.we = 1'b0; bus2.rd = 1'b1;
        tick();
        n_vec++;
        if (bus1.rd_valid !== 1'b1 || bus1.dout !== 8'hA5) begin
            n_err++;
            $display("FAIL raw_lat1: rv=%b dout=%h, expected 1 a5", bus1.rd_valid, bus1.dout);
        end
        n_vec++;
        if (bus2.rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL raw_lat2_early: rv=%b, expected 0", bus2.rd_valid);
        end
        idle_all();
        tick();
        n_vec++;
        if (bus2.rd_valid !== 1'b1 || bus2.dout !== 32'h000000A5) begin
            n_err++;
            $display("FAIL raw_lat2: rv=%b dout=%h, expected 1 000000a5", bus2.rd_valid, bus2.dout);
        end
        n_vec++;
        if (bus1.rd_valid !== 1'b0 || bus1.dout !== 8'hA5) begin
            n_err++;
            $display("FAIL lat1_hold: rv=%b dout=%h, expected 0 a5", bus1.rd_valid, bus1.dout);
        end
        tick();
    endtask

    task automatic test_byte_enable();
        bus2.cs = 1'b1; bus2.we = 1'b1; bus2.rd = 1'b0; bus2.addr = 5'd5;
        bus2.din = 32'h11223344; bus2.be = 4'b1111;
        tick();
        bus2.din = 32'hFFFFFFFF; bus2.be = 4'b0101;
        tick();
        bus2.din = 32'h00000000; bus2.be = 4'b0000;
        tick();
        n_vec++;
        if (bus2.err !== 1'b0) begin
            n_err++;
            $display("FAIL be_zero_err: err=%b, expected 0", bus2.err);
        end
        bus2.we = 1'b0; bus2.rd = 1'b1;
        tick();
        idle_all();
        tick();
        n_vec++;
        if (bus2.rd_valid !== 1'b1 || bus2.dout !== 32'h11FF33FF) begin
            n_err++;
            $display("FAIL byte_lanes: rv=%b dout=%h, expected 1 11ff33ff", bus2.rd_valid, bus2.dout);
        end
        tick();
    endtask

    task automatic test_errors();
        wr1(8'd2, 8'h3C);
        tick();
        bus1.we = 1'b1; bus1.rd = 1'b1; bus1.din = 8'hFF;
        tick();
        n_vec++;
        if (bus1.err !== 1'b1 || bus1.rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL err_we_rd: err=%b rv=%b, expected 1 0", bus1.err, bus1.rd_valid);
        end
        rd1(8'd20);
        tick();
        n_vec++;
        if (bus1.err !== 1'b1 || bus1.rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL err_range_rd: err=%b rv=%b, expected 1 0", bus1.err, bus1.rd_valid);
        end
        wr1(8'd20, 8'h77);
        tick();
        n_vec++;
        if (bus1.err !== 1'b1) begin
            n_err++;
            $display("FAIL err_range_wr: err=%b, expected 1", bus1.err);
        end
        idle_all();
        tick();
        n_vec++;
        if (bus1.err !== 1'b0 || bus1.rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL err_pulse_end: err=%b rv=%b, expected 0 0", bus1.err, bus1.rd_valid);
        end
        rd1(8'd2);
        tick();
        n_vec++;
        if (bus1.rd_valid !== 1'b1 || bus1.dout !== 8'h3C || bus1.err !== 1'b0) begin
            n_err++;
            $display("FAIL err_mem_intact: rv=%b dout=%h err=%b, expected 1 3c 0",
                     bus1.rd_valid, bus1.dout, bus1.err);
        end
        idle_all();
        tick();
    endtask

    task automatic test_reset_mid_clear();
        int n;
        int rv_seen;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        n_vec++;
        if (bus1.busy !== 1'b1) begin
            n_err++;
            $display("FAIL mid_clear_busy: busy=%b, expected 1", bus1.busy);
        end
        rd1(8'd0);
        rst_n = 1'b0;
        tick();
        n_vec++;
        if (bus1.dout !== 8'h00 || bus1.rd_valid !== 1'b0 || bus1.busy !== 1'b1) begin
            n_err++;
            $display("FAIL mid_clear_reset: dout=%h rv=%b busy=%b, expected 00 0 1",
                     bus1.dout, bus1.rd_valid, bus1.busy);
        end
        rst_n = 1'b1;
        n = 0;
        rv_seen = 0;
        while (bus1.busy === 1'b1 && n < 100) begin
            rd1(8'(n % 4));
            tick();
            if (bus1.rd_valid !== 1'b0 || bus1.err !== 1'b0) rv_seen++;
            n++;
        end
        idle_all();
        tick();
        if (bus1.rd_valid !== 1'b0) rv_seen++;
        n_vec++;
        if (n !== 16) begin
            n_err++;
            $display("FAIL restart_busy_length: got %0d cycles, expected 16", n);
        end
        n_vec++;
        if (rv_seen !== 0) begin
            n_err++;
            $display("FAIL busy_reads_dropped: %0d cycles with rv/err, expected 0", rv_seen);
        end
        n_vec++;
        if (bus1.dout !== 8'h00) begin
            n_err++;
            $display("FAIL restart_dout: dout=%h, expected 00", bus1.dout);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++) begin
            wr1(8'(k), 8'(8'h10 + k));
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            rd1(8'(k));
            tick();
            n_vec++;
            if (bus1.rd_valid !== 1'b1 || bus1.dout !== 8'(8'h10 + k)) begin
                n_err++;
                $display("FAIL b2b_lat1[%0d]: rv=%b dout=%h, expected 1 %h",
                         k, bus1.rd_valid, bus1.dout, 8'(8'h10 + k));
            end
        end
        idle_all();
        bus2.cs = 1'b1; bus2.we = 1'b1; bus2.be = 4'b1111;
        bus2.addr = 5'd7; bus2.din = 32'hCAFE0007;
        tick();
        bus2.addr = 5'd8; bus2.din = 32'hBEEF0008;
        tick();
        bus2.we = 1'b0; bus2.rd = 1'b1; bus2.addr = 5'd7;
        tick();
        n_vec++;
        if (bus2.rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_lat2_first: rv=%b, expected 0", bus2.rd_valid);
        end
        bus2.addr = 5'd8;
        tick();
        n_vec++;
        if (bus2.rd_valid !== 1'b1 || bus2.dout !== 32'hCAFE0007) begin
            n_err++;
            $display("FAIL b2b_lat2_a: rv=%b dout=%h, expected 1 cafe0007", bus2.rd_valid, bus2.dout);
        end
        idle_all();
        tick();
        n_vec++;
        if (bus2.rd_valid !== 1'b1 || bus2.dout !== 32'hBEEF0008) begin
            n_err++;
            $display("FAIL b2b_lat2_b: rv=%b dout=%h, expected 1 beef0008", bus2.rd_valid, bus2.dout);
        end
        tick();
        n_vec++;
        if (bus2.rd_valid !== 1'b0 || bus2.dout !== 32'hBEEF0008) begin
            n_err++;
            $display("FAIL b2b_lat2_hold: rv=%b dout=%h, expected 0 beef0008", bus2.rd_valid, bus2.dout);
        end
    endtask

    initial begin
        idle_all();
        test_reset();
        test_write_read();
        test_byte_enable();
        test_errors();
        test_reset_mid_clear();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
